reg_file_mp: RTL and testbench

Parametrised multi-port register file for the RISC-V core: configurable data width, depth, read-port count and two write ports. All state, including read-data outputs, is registered on the rising clock edge. Read-port stall holds and an optional same-cycle write-to-read bypass support a deeper pipeline with dual writeback (ALU and load/CSR paths). Sits between decode (read addresses) and writeback (write ports).

---
 rtl/reg_file_mp.sv | 110 +++++++++++
 tb/tb_reg_file_mp.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/reg_file_mp.sv
// Multi-port register file: two write ports, NREAD registered read ports with stall hold.
// Define REG_FILE_MP_BYPASS_EN to forward same-edge write data into colliding read lanes.

module reg_file_mp_lane #(
    parameter int DWIDTH   = 32,
    parameter int DEPTH    = 32,
    parameter int AWIDTH   = 5,
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ren,
    input  logic [AWIDTH-1:0] addr,
    input  logic [DWIDTH-1:0] entry,
`ifdef REG_FILE_MP_BYPASS_EN
    input  logic              wv0,
    input  logic [AWIDTH-1:0] wa0,
    input  logic [DWIDTH-1:0] wd0,
    input  logic              wv1,
    input  logic [AWIDTH-1:0] wa1,
    input  logic [DWIDTH-1:0] wd1,
`endif
    output logic [DWIDTH-1:0] rd
);
    logic              hit;
    logic [DWIDTH-1:0] nxt;

    assign hit = (int'(addr) < DEPTH) && !((ZERO_REG != 0) && (addr == '0));

    always_comb begin
        nxt = hit ? entry : '0;
`ifdef REG_FILE_MP_BYPASS_EN
        // wv* already exclude dropped writes, so a match implies a readable address
        if (wv0 && (wa0 == addr)) nxt = wd0;
        if (wv1 && (wa1 == addr)) nxt = wd1;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            rd <= '0;
        else if (ren)
            rd <= nxt;
    end
endmodule

module reg_file_mp #(
    parameter int DWIDTH   = 32,
    parameter int DEPTH    = 32,
    parameter int AWIDTH   = $clog2(DEPTH),
    parameter int NREAD    = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREAD-1:0]         ren,
    input  logic [NREAD*AWIDTH-1:0]  ra,
    output logic [NREAD*DWIDTH-1:0]  rd,
    input  logic                     we0,
    input  logic                     we1,
    input  logic [AWIDTH-1:0]        wa0,
    input  logic [AWIDTH-1:0]        wa1,
    input  logic [DWIDTH-1:0]        wd0,
    input  logic [DWIDTH-1:0]        wd1
);
    logic [DWIDTH-1:0] mem [DEPTH];
    logic              wv0, wv1;

    assign wv0 = we0 && (int'(wa0) < DEPTH) && !((ZERO_REG != 0) && (wa0 == '0));
    assign wv1 = we1 && (int'(wa1) < DEPTH) && !((ZERO_REG != 0) && (wa1 == '0));

    // Port 1 is written last so it wins a same-address dual write
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int e = 0; e < DEPTH; e++) mem[e] <= '0;
        end else begin
            if (wv0) mem[wa0] <= wd0;
            if (wv1) mem[wa1] <= wd1;
        end
    end

    for (genvar i = 0; i < NREAD; i++) begin : g_lane
        logic [AWIDTH-1:0] a;
        logic [DWIDTH-1:0] ent;
        assign a   = ra[i*AWIDTH +: AWIDTH];
        assign ent = (int'(a) < DEPTH) ? mem[a] : '0;

        reg_file_mp_lane #(
            .DWIDTH  (DWIDTH),
            .DEPTH   (DEPTH),
            .AWIDTH  (AWIDTH),
            .ZERO_REG(ZERO_REG)
        ) u_lane (
            .clk  (clk),
            .rst  (rst),
            .ren  (ren[i]),
            .addr (a),
            .entry(ent),
`ifdef REG_FILE_MP_BYPASS_EN
            .wv0  (wv0),
            .wa0  (wa0),
            .wd0  (wd0),
            .wv1  (wv1),
            .wa1  (wa1),
            .wd1  (wd1),
`endif
            .rd   (rd[i*DWIDTH +: DWIDTH])
        );
    end
endmodule

// File: tb/tb_reg_file_mp.sv
// Directed bench for reg_file_mp (DEPTH=24, NREAD=3, ZERO_REG=1); expectations follow
// REG_FILE_MP_BYPASS_EN when it is defined for the build.
module tb_reg_file_mp;
    localparam int DW = 32;
    localparam int DEPTH = 24;
    localparam int AW = 5;
    localparam int NR = 3;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NR-1:0]     ren = '0;
    logic [NR*AW-1:0]  ra  = '0;
    logic [NR*DW-1:0]  rd;
    logic              we0 = 1'b0, we1 = 1'b0;
    logic [AW-1:0]     wa0 = '0, wa1 = '0;
    logic [DW-1:0]     wd0 = '0, wd1 = '0;

    int total = 0;
    int bad   = 0;

    reg_file_mp #(.DWIDTH(DW), .DEPTH(DEPTH), .AWIDTH(AW), .NREAD(NR), .ZERO_REG(1)) dut (
        .clk(clk), .rst(rst), .ren(ren), .ra(ra), .rd(rd),
        .we0(we0), .we1(we1), .wa0(wa0), .wa1(wa1), .wd0(wd0), .wd1(wd1)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] lane(input int i);
        return rd[i*DW +: DW];
    endfunction

    task automatic set_rd(input int i, input int a);
        ren[i] = 1'b1;
        ra[i*AW +: AW] = a[AW-1:0];
    endtask

    task automatic wr(input int a, input logic [DW-1:0] d);
        we0 = 1'b1; wa0 = a[AW-1:0]; wd0 = d;
        tick();
        we0 = 1'b0;
    endtask

    task automatic rd1(input int a);
        set_rd(0, a);
        tick();
        ren = '0;
    endtask

    task automatic test_reset();
        #3;
        total++;
        if (rd !== '0) begin bad++; $display("FAIL reset_init rd=%h want=0", rd); end
        @(negedge clk); rst = 1'b0;
        wr(5, 32'hDEADBEEF);
        rd1(5);
        total++;
        if (lane(0) !== 32'hDEADBEEF) begin bad++; $display("FAIL reset_preload got=%h want=deadbeef", lane(0)); end
        rst = 1'b1;
        #2;
        total++;
        if (rd !== '0) begin bad++; $display("FAIL reset_async rd=%h want=0", rd); end
        rst = 1'b0;
        rd1(5);
        total++;
        if (lane(0) !== 32'h0) begin bad++; $display("FAIL reset_clears_entry got=%h want=0", lane(0)); end
    endtask

    task automatic test_dual_write();
        we0 = 1'b1; wa0 = 5'd3; wd0 = 32'h11111111;
        we1 = 1'b1; wa1 = 5'd3; wd1 = 32'h22222222;
        tick();
        we0 = 1'b0; we1 = 1'b0;
        rd1(3);
        total++;
        if (lane(0) !== 32'h22222222) begin bad++; $display("FAIL dual_same got=%h want=22222222", lane(0)); end
        we0 = 1'b1; wa0 = 5'd4; wd0 = 32'h11111111;
        we1 = 1'b1; wa1 = 5'd6; wd1 = 32'h22222222;
        tick();
        we0 = 1'b0; we1 = 1'b0;
        set_rd(0, 6); set_rd(1, 4);
        tick();
        ren = '0;
        total++;
        if (lane(1) !== 32'h11111111) begin bad++; $display("FAIL dual_diff_e4 got=%h want=11111111", lane(1)); end
        total++;
        if (lane(0) !== 32'h22222222) begin bad++; $display("FAIL dual_diff_e6 got=%h want=22222222", lane(0)); end
    endtask

    task automatic test_zero_reg();
        // lanes hold nonzero data beforehand so a stale lane cannot pass as zero
        set_rd(0, 3); set_rd(1, 3); set_rd(2, 4);
        tick();
        we0 = 1'b1; wa0 = 5'd0; wd0 = 32'hFFFFFFFF;
        set_rd(0, 0); set_rd(1, 0); set_rd(2, 0);
        tick();
        we0 = 1'b0;
        total++;
        if (rd !== '0) begin bad++; $display("FAIL zero_same_cycle rd=%h want=0", rd); end
        tick();
        ren = '0;
        total++;
        if (rd !== '0) begin bad++; $display("FAIL zero_after rd=%h want=0", rd); end
    endtask

    task automatic test_collision();
        logic [DW-1:0] exp;
        wr(7, 32'hA);
        we0 = 1'b1; wa0 = 5'd7; wd0 = 32'hB;
        set_rd(0, 7);
        tick();
        we0 = 1'b0; ren = '0;
`ifdef REG_FILE_MP_BYPASS_EN
        exp = 32'hB;
`else
        exp = 32'hA;
`endif
        total++;
        if (lane(0) !== exp) begin bad++; $display("FAIL collision got=%h want=%h", lane(0), exp); end
        rd1(7);
        total++;
        if (lane(0) !== 32'hB) begin bad++; $display("FAIL collision_next got=%h want=0000000b", lane(0)); end
        we0 = 1'b1; wa0 = 5'd7; wd0 = 32'hC;
        we1 = 1'b1; wa1 = 5'd7; wd1 = 32'hD;
        set_rd(2, 7);
        tick();
        we0 = 1'b0; we1 = 1'b0; ren = '0;
`ifdef REG_FILE_MP_BYPASS_EN
        exp = 32'hD;
`else
        exp = 32'hB;
`endif
        total++;
        if (lane(2) !== exp) begin bad++; $display("FAIL collision_prio got=%h want=%h", lane(2), exp); end
        set_rd(2, 7);
        tick();
        ren = '0;
        total++;
        if (lane(2) !== 32'hD) begin bad++; $display("FAIL collision_prio_next got=%h want=0000000d", lane(2)); end
    endtask

    task automatic test_stall();
        wr(2, 32'h55);
        rd1(2);
        total++;
        if (lane(0) !== 32'h55) begin bad++; $display("FAIL stall_load got=%h want=55", lane(0)); end
        ra[0 +: AW] = 5'd2;
        for (int c = 0; c < 3; c++) begin
            we0 = 1'b1; wa0 = 5'd2; wd0 = 32'h66;
            tick();
            total++;
            if (lane(0) !== 32'h55) begin bad++; $display("FAIL stall_hold c=%0d got=%h want=55", c, lane(0)); end
        end
        we0 = 1'b0;
        rd1(2);
        total++;
        if (lane(0) !== 32'h66) begin bad++; $display("FAIL stall_release got=%h want=66", lane(0)); end
    endtask

    task automatic test_range_ports();
        wr(23, 32'h2323_2323);
        wr(1, 32'h0101_0101);
        we1 = 1'b1; wa1 = 5'd30; wd1 = 32'h7777_7777;
        tick();
        we1 = 1'b0;
        set_rd(0, 30); set_rd(1, 23); set_rd(2, 1);
        tick();
        ren = '0;
        total++;
        if (lane(0) !== 32'h0) begin bad++; $display("FAIL range_addr30 got=%h want=0", lane(0)); end
        total++;
        if (lane(1) !== 32'h2323_2323) begin bad++; $display("FAIL range_e23 got=%h want=23232323", lane(1)); end
        total++;
        if (lane(2) !== 32'h0101_0101) begin bad++; $display("FAIL range_e1 got=%h want=01010101", lane(2)); end
    endtask

    initial begin
        test_reset();
        test_dual_write();
        test_zero_reg();
        test_collision();
        test_stall();
        test_range_ports();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
